// File: rtl/quad_corr_trigger_sched.sv
// Trigger scheduler behind one quad correlator: latency-matched valid pipe,
// threshold detect with peak pick, valid/ready trigger handoff and holdoff.
// Optional accepted-trigger statistics: define QUAD_CORR_SCHED_STATS_EN.
module quad_corr_trigger_sched #(
  parameter int unsigned LATENCY   = 9,
  parameter int unsigned CBITS     = 11,
  parameter int unsigned HOLD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CBITS-1:0]     corr0,
  input  logic [CBITS-1:0]     corr1,
  input  logic [CBITS-1:0]     corr2,
  input  logic [CBITS-1:0]     corr3,
  input  logic                 cfg_wr,
  input  logic [1:0]           cfg_addr,
  input  logic [15:0]          cfg_data,
  output logic                 cfg_ack,
  output logic                 trig_valid,
  input  logic                 trig_ready,
  output logic [1:0]           trig_index,
  output logic [CBITS-1:0]     trig_value,
  output logic                 busy,
  output logic [15:0]          trig_count
);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_PRESENT  = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LATENCY-1:0]   vpipe_q;
  logic                 corr_valid;
  logic [CBITS-1:0]     corr_a [4];
  logic [CBITS-1:0]     thr_q, thr_sh_q;
  logic [HOLD_BITS-1:0] hold_q, hold_sh_q, cnt_q, cnt_d;
  logic                 enable_q;
  logic [3:0]           hit;
  logic                 any_hit;
  logic [1:0]           peak_idx;
  logic [CBITS-1:0]     peak_val;
  logic                 accept;
  logic                 load_trig;
  logic                 unused_cfg;

  assign corr_valid = vpipe_q[LATENCY-1];
  assign accept     = trig_valid & trig_ready;
  assign corr_a[0]  = corr0;
  assign corr_a[1]  = corr1;
  assign corr_a[2]  = corr2;
  assign corr_a[3]  = corr3;
  assign unused_cfg = ^cfg_data;

  // Valid pipe matching correlator latency; runs regardless of FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpipe_q <= '0;
    end else begin
      vpipe_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vpipe_q[i] <= vpipe_q[i-1];
    end
  end

  // Threshold hits and peak select; strict '>' keeps the lowest index on ties.
  always_comb begin
    hit      = '0;
    any_hit  = 1'b0;
    peak_idx = '0;
    peak_val = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = corr_valid && (corr_a[i] > thr_q);
      if (hit[i] && (!any_hit || (corr_a[i] > peak_val))) begin
        any_hit  = 1'b1;
        peak_idx = 2'(i);
        peak_val = corr_a[i];
      end
    end
  end

  // Next-state logic; disable is deferred while a trigger is outstanding.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_trig = 1'b0;
    case (state_q)
      S_DISARMED: begin
        if (enable_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!enable_q) begin
          state_d = S_DISARMED;
        end else if (any_hit) begin
          state_d   = S_PRESENT;
          load_trig = 1'b1;
        end
      end
      S_PRESENT: begin
        if (accept) begin
          if (!enable_q) begin
            state_d = S_DISARMED;
          end else if (hold_q == '0) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_HOLDOFF;
            cnt_d   = hold_q;
          end
        end
      end
      S_HOLDOFF: begin
        if (!enable_q) begin
          state_d = S_DISARMED;
        end else if (cnt_q == HOLD_BITS'(1)) begin
          state_d = S_ARMED;
        end else begin
          cnt_d = cnt_q - HOLD_BITS'(1);
        end
      end
      default: state_d = S_DISARMED;
    endcase
  end

  // State, holdoff counter and registered trigger outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_DISARMED;
      cnt_q      <= '0;
      trig_valid <= 1'b0;
      busy       <= 1'b0;
      trig_index <= '0;
      trig_value <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_valid <= (state_d == S_PRESENT);
      busy       <= (state_d == S_PRESENT) || (state_d == S_HOLDOFF);
      if (load_trig) begin
        trig_index <= peak_idx;
        trig_value <= peak_val;
      end
    end
  end

  // Config port: shadows take writes, actives follow only when idle or armed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ack   <= 1'b0;
      enable_q  <= 1'b0;
      thr_sh_q  <= '1;
      thr_q     <= '1;
      hold_sh_q <= '0;
      hold_q    <= '0;
    end else begin
      cfg_ack <= cfg_wr;
      if (cfg_wr) begin
        case (cfg_addr)
          2'd0:    thr_sh_q  <= cfg_data[CBITS-1:0];
          2'd1:    hold_sh_q <= cfg_data[HOLD_BITS-1:0];
          2'd2:    enable_q  <= cfg_data[0];
          default: ;
        endcase
      end
      if ((state_d == S_DISARMED) || (state_d == S_ARMED)) begin
        thr_q  <= thr_sh_q;
        hold_q <= hold_sh_q;
      end
    end
  end

`ifdef QUAD_CORR_SCHED_STATS_EN
  // Accepted-trigger counter; control write with bit1 set clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_count <= '0;
    end else if (cfg_wr && (cfg_addr == 2'd2) && cfg_data[1]) begin
      trig_count <= '0;
    end else if (accept) begin
      trig_count <= trig_count + 16'd1;
    end
  end
`else
  assign trig_count = 16'd0;
`endif

endmodule

// File: tb/tb_quad_corr_trigger_sched.sv
// Self-checking bench for quad_corr_trigger_sched: vector table plus
// handshake scoreboard and hand-written holdoff/backpressure/reset sequences.
`timescale 1ns/1ps
module tb_quad_corr_trigger_sched;
  localparam int unsigned LAT = 9;
  localparam int unsigned CB  = 11;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, cfg_wr, trig_ready;
  logic          cfg_ack, trig_valid, busy;
  logic [CB-1:0] corr0, corr1, corr2, corr3, trig_value;
  logic [1:0]    cfg_addr, trig_index;
  logic [15:0]   cfg_data, trig_count;

  typedef struct {
    logic [CB-1:0] c0, c1, c2, c3;
    bit            trig;
    logic [1:0]    idx;
    logic [CB-1:0] val;
  } vec_t;

  typedef struct {
    logic [1:0]    idx;
    logic [CB-1:0] val;
  } exp_t;

  exp_t          sb[$];
  exp_t          e_m;
  vec_t          vecs[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc_total = 0;
  int            acc_cyc[$];
  int            hold_seen[$];
  int            hold_run = 0;
  bit            holding = 1'b0;
  logic [1:0]    held_idx;
  logic [CB-1:0] held_val;

  quad_corr_trigger_sched #(.LATENCY(LAT), .CBITS(CB), .HOLD_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .corr0(corr0), .corr1(corr1), .corr2(corr2), .corr3(corr3),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .trig_valid(trig_valid), .trig_ready(trig_ready),
    .trig_index(trig_index), .trig_value(trig_value),
    .busy(busy), .trig_count(trig_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Handshake monitor: payload stability under stall, scoreboard pop on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (trig_valid) begin
        if (holding) begin
          chk("stall_idx_stable", 32'(trig_index), 32'(held_idx));
          chk("stall_val_stable", 32'(trig_value), 32'(held_val));
        end
        holding  = !trig_ready;
        held_idx = trig_index;
        held_val = trig_value;
        if (trig_ready) begin
          acc_total++;
          acc_cyc.push_back(cyc);
          hold_seen.push_back(hold_run);
          hold_run = 0;
          if (sb.size() == 0) begin
            chk("unexpected_trigger", 32'(trig_index), 32'hFFFF_FFFF);
          end else begin
            e_m = sb.pop_front();
            chk("sb_idx", 32'(trig_index), 32'(e_m.idx));
            chk("sb_val", 32'(trig_value), 32'(e_m.val));
          end
        end
      end else begin
        holding = 1'b0;
        if (busy) hold_run++;
      end
    end else begin
      holding = 1'b0;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    step;
    chk("cfg_ack_pulse", 32'(cfg_ack), 32'd1);
    cfg_wr = 1'b0;
    step;
    chk("cfg_ack_low", 32'(cfg_ack), 32'd0);
  endtask

  function automatic vec_t mk_vec(input int a, input int b, input int c, input int d, input int thr);
    vec_t v;
    int   cs[4];
    cs = '{a, b, c, d};
    v.c0 = CB'(a); v.c1 = CB'(b); v.c2 = CB'(c); v.c3 = CB'(d);
    v.trig = 1'b0; v.idx = 2'd0; v.val = '0;
    for (int i = 0; i < 4; i++) begin
      if (cs[i] > thr && (!v.trig || cs[i] > int'(v.val))) begin
        v.trig = 1'b1; v.idx = 2'(i); v.val = CB'(cs[i]);
      end
    end
    return v;
  endfunction

  // One in_valid pulse; correlator data shown one cycle early and on the valid cycle.
  task automatic run_vec(input vec_t v, input bit do_wr, input logic [15:0] wr_d);
    exp_t e;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    repeat (LAT - 2) step;
    corr0 = v.c0; corr1 = v.c1; corr2 = v.c2; corr3 = v.c3;
    step;
    chk("no_trig_before_latency", 32'(trig_valid), 32'd0);
    if (do_wr) begin
      cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_data = wr_d;
    end
    if (v.trig) begin
      e.idx = v.idx; e.val = v.val;
      sb.push_back(e);
    end
    step;
    cfg_wr = 1'b0;
    corr0 = '0; corr1 = '0; corr2 = '0; corr3 = '0;
    chk("trig_valid_at_latency_plus1", 32'(trig_valid), 32'(v.trig));
    if (v.trig) begin
      chk("trig_index", 32'(trig_index), 32'(v.idx));
      chk("trig_value", 32'(trig_value), 32'(v.val));
    end
  endtask

  // Continuous hits sized to yield exactly three triggers for holdoff h.
  task automatic run_holdoff(input int h);
    exp_t e;
    int   k, g;
    cfg_write(2'd1, 16'(h));
    step;
    acc_cyc.delete(); hold_seen.delete(); hold_run = 0;
    k = 2 * (h + 2) + 1;
    e.idx = 2'd2; e.val = CB'(400);
    repeat (3) sb.push_back(e);
    corr2 = CB'(400);
    in_valid = 1'b1;
    repeat (k) step;
    in_valid = 1'b0;
    g = 0;
    while (sb.size() != 0 && g < 200) begin step; g++; end
    chk("holdoff_sb_drained", 32'(sb.size()), 32'd0);
    repeat (LAT + h + 4) step;
    corr2 = '0;
    chk("holdoff_accept_count", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      for (int i = 1; i < 3; i++) begin
        // accept cycle, h holdoff cycles, one armed detect cycle
        chk("accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(h + 2));
        chk("holdoff_cycles", 32'(hold_seen[i]), 32'(h));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    corr0 = '0; corr1 = '0; corr2 = '0; corr3 = '0; trig_ready = 1'b1;

    // Vector table at threshold 100
    vecs.push_back('{CB'(0),    CB'(0),    CB'(200),  CB'(0),    1'b1, 2'd2, CB'(200)});
    vecs.push_back('{CB'(150),  CB'(300),  CB'(300),  CB'(50),   1'b1, 2'd1, CB'(300)});
    vecs.push_back('{CB'(0),    CB'(100),  CB'(0),    CB'(0),    1'b0, 2'd0, CB'(0)});
    vecs.push_back('{CB'(101),  CB'(0),    CB'(0),    CB'(0),    1'b1, 2'd0, CB'(101)});
    vecs.push_back('{CB'(2047), CB'(2047), CB'(2047), CB'(2047), 1'b1, 2'd0, CB'(2047)});
    vecs.push_back('{CB'(50),   CB'(60),   CB'(70),   CB'(80),   1'b0, 2'd0, CB'(0)});
    vecs.push_back('{CB'(0),    CB'(0),    CB'(0),    CB'(101),  1'b1, 2'd3, CB'(101)});
    vecs.push_back('{CB'(100),  CB'(100),  CB'(100),  CB'(100),  1'b0, 2'd0, CB'(0)});
    vecs.push_back('{CB'(500),  CB'(400),  CB'(600),  CB'(600),  1'b1, 2'd2, CB'(600)});
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk_vec(int'($urandom_range(0, 15)) * 128, int'($urandom_range(0, 15)) * 128,
                            int'($urandom_range(0, 15)) * 128, int'($urandom_range(0, 15)) * 128, 100));

    repeat (3) step;
    chk("rst_trig_valid", 32'(trig_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    chk("rst_trig_index", 32'(trig_index), 32'd0);
    chk("rst_trig_value", 32'(trig_value), 32'd0);
    chk("rst_trig_count", 32'(trig_count), 32'd0);
    rst_n = 1'b1;
    step;

    // Disabled after reset: no trigger even above threshold
    cfg_write(2'd0, 16'd100);
    run_vec(mk_vec(2047, 0, 0, 0, 5000), 1'b0, 16'd0);
    repeat (2) step;
    // Enabled with reset threshold restored to all-ones: strict compare blocks 2047
    rst_n = 1'b0; step; rst_n = 1'b1; step;
    cfg_write(2'd2, 16'd1);
    run_vec(mk_vec(2047, 2047, 2047, 2047, 2047), 1'b0, 16'd0);
    repeat (2) step;
    cfg_write(2'd0, 16'd100);
    step;

    foreach (vecs[i]) begin
      run_vec(vecs[i], 1'b0, 16'd0);
      repeat (3) step;
    end

    // Threshold write in the detection cycle uses the old threshold
    run_vec(mk_vec(300, 0, 0, 0, 100), 1'b1, 16'd500);
    repeat (3) step;
    run_vec(mk_vec(300, 0, 0, 0, 500), 1'b0, 16'd0);
    repeat (2) step;
    run_vec(mk_vec(0, 501, 0, 0, 500), 1'b0, 16'd0);
    repeat (3) step;
    cfg_write(2'd0, 16'd100);
    step;

    // Backpressure: held payload, later hits dropped, nothing queued
    trig_ready = 1'b0;
    run_vec(mk_vec(0, 0, 0, 500, 100), 1'b0, 16'd0);
    corr0 = CB'(900); corr1 = CB'(900); corr2 = CB'(900); corr3 = CB'(900);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 5);
      step;
    end
    in_valid = 1'b0;
    corr0 = '0; corr1 = '0; corr2 = '0; corr3 = '0;
    chk("bp_still_valid", 32'(trig_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    trig_ready = 1'b1;
    step;
    chk("bp_valid_drop_after_accept", 32'(trig_valid), 32'd0);
    repeat (LAT + 3) step;
    chk("bp_no_queued_trigger", 32'(trig_valid), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

`ifdef QUAD_CORR_SCHED_STATS_EN
    chk("trig_count_total", 32'(trig_count), 32'(16'(acc_total)));
`else
    chk("trig_count_tied", 32'(trig_count), 32'd0);
`endif

    // Holdoff spacing
    run_holdoff(5);
    run_holdoff(0);

    // Disable while presenting: held until accept, then disarmed
    cfg_write(2'd2, 16'd3);
`ifdef QUAD_CORR_SCHED_STATS_EN
    chk("trig_count_cleared", 32'(trig_count), 32'd0);
`endif
    trig_ready = 1'b0;
    run_vec(mk_vec(0, 700, 0, 0, 100), 1'b0, 16'd0);
    cfg_write(2'd2, 16'd0);
    repeat (4) step;
    chk("dis_present_valid_held", 32'(trig_valid), 32'd1);
    chk("dis_present_busy", 32'(busy), 32'd1);
    chk("dis_present_idx", 32'(trig_index), 32'd1);
    trig_ready = 1'b1;
    step;
    chk("dis_valid_after_accept", 32'(trig_valid), 32'd0);
    chk("dis_busy_after_accept", 32'(busy), 32'd0);
`ifdef QUAD_CORR_SCHED_STATS_EN
    chk("dis_trig_count", 32'(trig_count), 32'd1);
`else
    chk("dis_trig_count", 32'(trig_count), 32'd0);
`endif
    step;
    run_vec(mk_vec(0, 0, 800, 0, 5000), 1'b0, 16'd0);
    repeat (2) step;

    // Reset mid-PRESENT drops the trigger silently
    cfg_write(2'd2, 16'd1);
    step;
    trig_ready = 1'b0;
    run_vec(mk_vec(0, 0, 0, 300, 100), 1'b0, 16'd0);
    void'(sb.pop_back());
    rst_n = 1'b0;
    repeat (3) step;
    chk("rst2_trig_valid", 32'(trig_valid), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_trig_index", 32'(trig_index), 32'd0);
    chk("rst2_trig_value", 32'(trig_value), 32'd0);
    chk("rst2_trig_count", 32'(trig_count), 32'd0);
    chk("rst2_cfg_ack", 32'(cfg_ack), 32'd0);
    rst_n = 1'b1;
    trig_ready = 1'b1;
    step;
    run_vec(mk_vec(2047, 2047, 2047, 2047, 5000), 1'b0, 16'd0);
    repeat (3) step;
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("accepted triggers observed: %0d", acc_total);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
